// File: rtl/prbs_3b_checker.sv
// prbs_3b_checker: receive-side checker for the 3-bit LFSR stream
// nxt(s) = {s[1:0], s[2]^s[1]}.
// It hunts for a non-zero seed and confirms LOCK_CNT consistent samples
// before it locks. While locked it flags and counts mismatches. It drops
// lock after LOSS_CNT consecutive misses.
// Optional feature macro: PRBS3_ZERO_DET_EN. When it is defined, a 000
// sample while locked forces HUNT, and the design adds a sticky
// zero_seen output.
module prbs_3b_checker #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,   // 2..7
    parameter int LOSS_CNT = 2    // 1..7
) (
    input  logic             clk,
    input  logic             reset,      // async, active-low
    input  logic             valid_in,
    input  logic [2:0]       data_in,
    input  logic             clr_cnt,
    output logic             lock,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
`ifdef PRBS3_ZERO_DET_EN
    output logic             zero_seen,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [2:0] nxt(input logic [2:0] s);
        return {s[1:0], s[2] ^ s[1]};
    endfunction

    state_t           st, st_n;
    logic [2:0]       expected, exp_n;
    logic [2:0]       run_cnt, run_n, run_inc;
    logic [2:0]       miss_cnt, miss_n, miss_inc;
    logic             err_n;
    logic [CNT_W-1:0] cnt_n;
`ifdef PRBS3_ZERO_DET_EN
    logic             zs_n;
`endif

    assign run_inc  = run_cnt + 3'd1;
    assign miss_inc = miss_cnt + 3'd1;
    assign state    = st;

    // State and output registers; outputs clear asynchronously on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= HUNT;
            expected  <= 3'b000;
            run_cnt   <= 3'd0;
            miss_cnt  <= 3'd0;
            lock      <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
`ifdef PRBS3_ZERO_DET_EN
            zero_seen <= 1'b0;
`endif
        end else begin
            st        <= st_n;
            expected  <= exp_n;
            run_cnt   <= run_n;
            miss_cnt  <= miss_n;
            lock      <= (st_n == LOCKED);
            err_pulse <= err_n;
            err_count <= cnt_n;
`ifdef PRBS3_ZERO_DET_EN
            zero_seen <= zs_n;
`endif
        end
    end

    // Next-state logic. The clear is applied before the increment, so a
    // clear and a mismatch on the same edge leave the count at 1.
    always_comb begin
        st_n   = st;
        exp_n  = expected;
        run_n  = run_cnt;
        miss_n = miss_cnt;
        err_n  = 1'b0;
        cnt_n  = clr_cnt ? '0 : err_count;
`ifdef PRBS3_ZERO_DET_EN
        zs_n   = clr_cnt ? 1'b0 : zero_seen;
        if (valid_in && data_in == 3'b000)
            zs_n = 1'b1;
`endif
        if (valid_in) begin
            unique case (st)
                HUNT: begin
                    if (data_in != 3'b000) begin
                        exp_n = nxt(data_in);
                        run_n = 3'd1;
                        st_n  = SYNC;
                    end
                end
                SYNC: begin
                    if (data_in == expected) begin
                        exp_n = nxt(expected);
                        run_n = run_inc;
                        if (run_inc == 3'(LOCK_CNT)) begin
                            st_n   = LOCKED;
                            miss_n = 3'd0;
                        end
                    end else if (data_in != 3'b000) begin
                        // Reseed from the offending sample
                        exp_n = nxt(data_in);
                        run_n = 3'd1;
                    end else begin
                        st_n = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances regardless of match
                    exp_n = nxt(expected);
                    if (data_in == expected) begin
                        miss_n = 3'd0;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_inc;
                        if (cnt_n != CNT_MAX)
                            cnt_n = cnt_n + CNT_W'(1);
                        if (miss_inc == 3'(LOSS_CNT))
                            st_n = HUNT;
`ifdef PRBS3_ZERO_DET_EN
                        if (data_in == 3'b000)
                            st_n = HUNT;
`endif
                    end
                end
                default: st_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_3b_checker.sv
// Directed bench for prbs_3b_checker. CNT_W=2 is used so that saturation
// is reachable. Each step pushes its hand-derived expected outputs
// {state, lock, err_pulse, err_count} onto a queue. After the edge, the
// bench pops that entry and compares it with the DUT outputs.
module tb_prbs_3b_checker;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [2:0]    data_in;
    logic          clr_cnt;
    logic          lock;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [1:0]    state;
`ifdef PRBS3_ZERO_DET_EN
    logic          zero_seen;
`endif

    typedef struct {
        string        tag;
        logic [CW+3:0] v;
    } sb_t;

    sb_t        sbq[$];
    int         checks   = 0;
    int         failures = 0;
    int         idx;
    logic [2:0] seqv [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};

    prbs_3b_checker #(.CNT_W(CW), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .clr_cnt   (clr_cnt),
        .lock      (lock),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef PRBS3_ZERO_DET_EN
        .zero_seen (zero_seen),
`endif
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] wrong(input logic [2:0] v);
        return (v == 3'b001) ? 3'b010 : 3'b001;
    endfunction

    task automatic push(input string tag, input logic [1:0] st, input logic lk,
                        input logic p, input logic [CW-1:0] c);
        sb_t e;
        e.tag = tag;
        e.v   = {st, lk, p, c};
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        sb_t           e;
        logic [CW+3:0] obs;
        e   = sbq.pop_front();
        obs = {state, lock, err_pulse, err_count};
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (state,lock,pulse,count)", e.tag, obs, e.v);
        end
    endtask

    // Drive at the falling edge, then check 1 time unit after the rising edge
    task automatic step(input string tag, input logic v, input logic [2:0] d, input logic c,
                        input logic [1:0] st, input logic lk, input logic p,
                        input logic [CW-1:0] cn);
        valid_in = v;
        data_in  = d;
        clr_cnt  = c;
        push(tag, st, lk, p, cn);
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 3'b000;
        clr_cnt  = 1'b0;
        repeat (2) @(negedge clk);
        push("reset_state", 2'd0, 1'b0, 1'b0, 2'd0);
        pop_check();
        reset = 1'b1;

        // Clean lock: 0 -> 1 -> 1 -> 1 -> 2
        step("lock_s1", 1, 3'b001, 0, 2'd1, 0, 0, 2'd0);
        step("lock_s2", 1, 3'b010, 0, 2'd1, 0, 0, 2'd0);
        step("lock_s3", 1, 3'b101, 0, 2'd1, 0, 0, 2'd0);
        step("lock_s4", 1, 3'b011, 0, 2'd2, 1, 0, 2'd0);
        for (int i = 4; i < 18; i++)
            step("locked_clean", 1, seqv[i % 7], 0, 2'd2, 1, 0, 2'd0);

        // Single error: 000 in place of 111
`ifdef PRBS3_ZERO_DET_EN
        step("single_err", 1, 3'b000, 0, 2'd0, 0, 1, 2'd1);
        checks++;
        assert (zero_seen === 1'b1) else begin
            failures++;
            $error("FAIL zero_seen observed=%b expected=1", zero_seen);
        end
        step("after_err_110", 1, 3'b110, 0, 2'd1, 0, 0, 2'd1);
        step("after_err_100", 1, 3'b100, 0, 2'd1, 0, 0, 2'd1);
        step("after_err_001", 1, 3'b001, 0, 2'd1, 0, 0, 2'd1);
        step("after_err_010", 1, 3'b010, 0, 2'd2, 1, 0, 2'd1);
`else
        step("single_err", 1, 3'b000, 0, 2'd2, 1, 1, 2'd1);
        step("after_err_110", 1, 3'b110, 0, 2'd2, 1, 0, 2'd1);
        step("after_err_100", 1, 3'b100, 0, 2'd2, 1, 0, 2'd1);
        step("after_err_001", 1, 3'b001, 0, 2'd2, 1, 0, 2'd1);
        step("after_err_010", 1, 3'b010, 0, 2'd2, 1, 0, 2'd1);
`endif
        step("clr_on_match", 1, 3'b101, 1, 2'd2, 1, 0, 2'd0);

        // Loss of lock: expected 011, 111 but 101, 101 arrive
        step("loss_miss1", 1, 3'b101, 0, 2'd2, 1, 1, 2'd1);
        step("loss_miss2", 1, 3'b101, 0, 2'd0, 0, 1, 2'd2);
        step("loss_idle", 0, 3'b000, 0, 2'd0, 0, 0, 2'd2);

        // SYNC reseed at 100, lock after 101
        step("rs_001", 1, 3'b001, 0, 2'd1, 0, 0, 2'd2);
        step("rs_010", 1, 3'b010, 0, 2'd1, 0, 0, 2'd2);
        step("rs_100", 1, 3'b100, 0, 2'd1, 0, 0, 2'd2);
        step("rs_001b", 1, 3'b001, 0, 2'd1, 0, 0, 2'd2);
        step("rs_010b", 1, 3'b010, 0, 2'd1, 0, 0, 2'd2);
        step("rs_101", 1, 3'b101, 0, 2'd2, 1, 0, 2'd2);

        // Gaps in valid_in hold state
        step("gap1", 0, 3'b000, 0, 2'd2, 1, 0, 2'd2);
        step("gap2", 0, 3'b111, 0, 2'd2, 1, 0, 2'd2);
        step("gap_011", 1, 3'b011, 0, 2'd2, 1, 0, 2'd2);
        step("gap3", 0, 3'b000, 0, 2'd2, 1, 0, 2'd2);
        step("gap_111", 1, 3'b111, 0, 2'd2, 1, 0, 2'd2);

        // Five isolated errors: the count saturates at 3
        idx = 5;
        for (int k = 0; k < 5; k++) begin
            step("sat_err", 1, wrong(seqv[idx % 7]), 0, 2'd2, 1, 1, 2'd3);
            idx++;
            step("sat_match", 1, seqv[idx % 7], 0, 2'd2, 1, 0, 2'd3);
            idx++;
        end
        step("clr_idle", 0, 3'b000, 1, 2'd2, 1, 0, 2'd0);
        step("sat_err_again", 1, wrong(seqv[idx % 7]), 0, 2'd2, 1, 1, 2'd1);
        idx++;
        step("sat_match2", 1, seqv[idx % 7], 0, 2'd2, 1, 0, 2'd1);
        idx++;
        step("clr_with_err", 1, wrong(seqv[idx % 7]), 1, 2'd2, 1, 1, 2'd1);
        idx++;
        step("post_clr_match", 1, seqv[idx % 7], 0, 2'd2, 1, 0, 2'd1);
        idx++;

        // Async reset between edges, then a relock is needed
        valid_in = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        push("async_reset", 2'd0, 1'b0, 1'b0, 2'd0);
        pop_check();
        @(negedge clk);
        reset = 1'b1;
        step("relock_s1", 1, 3'b011, 0, 2'd1, 0, 0, 2'd0);
        step("relock_s2", 1, 3'b111, 0, 2'd1, 0, 0, 2'd0);
        step("relock_s3", 1, 3'b110, 0, 2'd1, 0, 0, 2'd0);
        step("relock_s4", 1, 3'b100, 0, 2'd2, 1, 0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
